// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the execute stage.
// 32-cycle shift-add multiply and 32-cycle restoring divide on operand
// magnitudes. Sign correction is applied on the final iteration. Divide-by-zero
// and signed overflow bypass the iteration.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiply
// (IDLE -> DONE). Divide is unaffected.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          count_q, count_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
  logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
  logic                neg_q, neg_d;
  logic [2:0]          func3_q, func3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic                done_q, done_d;

  // Operand sign handling: rs1 signed except MULHU/DIVU/REMU, rs2 signed only
  // for MUL/MULH/DIV/REM.
  logic            sa_in, sb_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  assign sa_in    = rs1_val[XLEN-1] & ~(func3[0] & (func3[1] | func3[2]));
  assign sb_in    = rs2_val[XLEN-1] & ((func3 == 3'b000) | (func3 == 3'b001) |
                                       (func3 == 3'b100) | (func3 == 3'b110));
  assign mag_a    = sa_in ? (~rs1_val + 1'b1) : rs1_val;
  assign mag_b    = sb_in ? (~rs2_val + 1'b1) : rs2_val;
  assign div_zero = func3[2] & (rs2_val == '0);
  assign div_ovf  = func3[2] & ~func3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &
                    (rs2_val == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_p;
  assign fast_a = $signed({sa_in, rs1_val});
  assign fast_b = $signed({sb_in, rs2_val});
  assign fast_p = fast_a * fast_b;
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]     mul_sum, div_top, div_diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, opb_q};
    if (func3_q[2]) begin
      if (div_diff[XLEN]) step = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? (~step + 1'b1) : step;
    quo_fix  = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
    rem_fix  = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
    if (func3_q[2])              fin_res = func3_q[1] ? rem_fix : quo_fix;
    else if (func3_q[1:0] == 2'b00) fin_res = prod_fix[XLEN-1:0];
    else                         fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state, datapath load/update and output registers.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          func3_d = func3;
          rd_d    = rd_in;
          count_d = '0;
          neg_d   = (func3[2] & func3[1]) ? sa_in : (sa_in ^ sb_in);
          if (func3[2]) begin
            acc_d = {{XLEN{1'b0}}, mag_a};
            opb_d = mag_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, mag_b};
            opb_d = mag_a;
          end
          if (div_zero) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = func3[1] ? rs1_val : '1;
            rd_out_d = rd_in;
          end else if (div_ovf) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = func3[1] ? '0 : rs1_val;
            rd_out_d = rd_in;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!func3[2]) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = (func3[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
            rd_out_d = rd_in;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = fin_res;
            rd_out_d = rd_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      func3_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign stall  = ((state_q == IDLE) & start & ~flush) | ((state_q == CALC) & ~flush);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed bench for ex_muldiv_unit with a
// plain-arithmetic RV32M reference model. Honours MULDIV_FAST_MUL_EN.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [2:0]  func3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .stall(stall),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Reference result from the RV32M arithmetic rules.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Cycle (counting start as 0) in which done is expected.
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f[2]) return FAST ? 1 : 33;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one instruction, hold start while stalled and through DONE, and
  // report what the DUT produced.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int dcyc, output int scnt,
                        output logic dafter);
    @(negedge clk);
    start = 1'b1; func3 = f; rs1_val = a; rs2_val = b; rd_in = rd;
    dcyc = -1; scnt = 0; res = 32'h0; rdo = 5'h0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stall) scnt++;
      if (done) begin
        dcyc = c; res = result; rdo = rd_out;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    dafter = done;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; func3 = 3'd0;
    rs1_val = 0; rs2_val = 0; rd_in = 0;
    #12;
    total++;
    if ({busy, done, result, rd_out, stall} !== 40'h0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b result=%h rd_out=%0d stall=%b want all zero",
               busy, done, result, rd_out, stall);
    end
    start = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL reset_stall_eq got %b want 1", stall);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  f  [14] = '{0, 1, 3, 2, 4, 6, 5, 7, 5, 7, 4, 6, 4, 6};
    logic [31:0] va [14] = '{7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'hFFFFFFF9, 100, 100, 17, 17, 32'h80000000, 32'h80000000,
                             5, 32'hFFFFFFF9};
    logic [31:0] vb [14] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 2, 2, 2, 7, 7, 0, 0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    logic [31:0] ex [14] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 14, 2, 32'hFFFFFFFF, 17,
                             32'h80000000, 0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] res; logic [4:0] rdo; int dc, sc; logic da;
    for (int i = 0; i < 14; i++) begin
      run_op(f[i], va[i], vb[i], 5'(i + 1), res, rdo, dc, sc, da);
      total++;
      if (res !== ex[i] || rdo !== 5'(i + 1)) begin
        bad++;
        $display("FAIL directed_%0d result got %h rd=%0d want %h rd=%0d", i, res, rdo, ex[i], i + 1);
      end
      total++;
      if (dc != ref_lat(f[i], va[i], vb[i]) || sc != ref_lat(f[i], va[i], vb[i]) || da !== 1'b0) begin
        bad++;
        $display("FAIL directed_%0d timing got done_cyc=%0d stall_cycles=%0d done_after=%b want %0d %0d 0",
                 i, dc, sc, da, ref_lat(f[i], va[i], vb[i]), ref_lat(f[i], va[i], vb[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b; logic [4:0] rdo, rd; logic [2:0] f; int dc, sc; logic da;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      rd = 5'($urandom);
      run_op(f, a, b, rd, res, rdo, dc, sc, da);
      total++;
      if (res !== ref_res(f, a, b) || rdo !== rd || dc != ref_lat(f, a, b) || sc != ref_lat(f, a, b)) begin
        bad++;
        $display("FAIL random_%0d f=%0d a=%h b=%h got res=%h rd=%0d cyc=%0d stall=%0d want res=%h rd=%0d cyc=%0d",
                 i, f, a, b, res, rdo, dc, sc, ref_res(f, a, b), rd, ref_lat(f, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; logic [4:0] d1, d2; int c1, c2, s1, s2; logic a1, a2;
    run_op(3'd5, 32'd1000, 32'd9, 5'd3, r1, d1, c1, s1, a1);
    run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd4, r2, d2, c2, s2, a2);
    total++;
    if (r1 !== 32'd111 || d1 !== 5'd3 || c1 != 33) begin
      bad++; $display("FAIL b2b_first got res=%h rd=%0d cyc=%0d want 0000006f 3 33", r1, d1, c1);
    end
    total++;
    if (r2 !== ref_res(3'd3, 32'hDEADBEEF, 32'h12345678) || d2 !== 5'd4 ||
        c2 != ref_lat(3'd3, 32'hDEADBEEF, 32'h12345678)) begin
      bad++;
      $display("FAIL b2b_second got res=%h rd=%0d cyc=%0d want %h 4 %0d", r2,
               d2, c2, ref_res(3'd3, 32'hDEADBEEF, 32'h12345678), ref_lat(3'd3, 32'hDEADBEEF, 32'h12345678));
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int dc, sc, seen; logic da;
    run_op(3'd5, 32'd100, 32'd7, 5'd9, res, rdo, dc, sc, da);
    total++;
    if (res !== 32'd14) begin bad++; $display("FAIL flush_pre got %h want 0000000e", res); end
    @(negedge clk);
    start = 1'b1; func3 = 3'd4; rs1_val = 32'h12345678; rs2_val = 32'd3; rd_in = 5'd2;
    for (int c = 0; c < 10; c++) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL flush_calc got busy=%b stall=%b want 1 1", busy, stall);
    end
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got %b want 0", stall); end
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
      bad++;
      $display("FAIL flush_after got busy=%b stall=%b done=%b result=%h want 0 0 0 0000000e",
               busy, stall, done, result);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (done) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_no_done got %0d done cycles want 0", seen); end
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd6, res, rdo, dc, sc, da);
    total++;
    if (res !== 32'hFFFFFFEB || rdo !== 5'd6 || dc != ref_lat(3'd0, 7, 32'hFFFFFFFD)) begin
      bad++; $display("FAIL flush_next_mul got res=%h rd=%0d cyc=%0d want ffffffeb 6 %0d",
                      res, rdo, dc, ref_lat(3'd0, 7, 32'hFFFFFFFD));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; int dc, sc, seen; logic da;
    @(negedge clk);
    start = 1'b1; func3 = 3'd4; rs1_val = 32'hFFFF0000; rs2_val = 32'd5; rd_in = 5'd11;
    for (int c = 0; c < 15; c++) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    total++;
    if ({busy, done, result, rd_out, stall} !== 40'h0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h rd_out=%0d stall=%b want all zero",
               busy, done, result, rd_out, stall);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (done) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid_no_done got %0d want 0", seen); end
    run_op(3'd7, 32'd100, 32'd7, 5'd5, res, rdo, dc, sc, da);
    total++;
    if (rdo !== 5'd5 || res !== 32'd2 || dc != 33) begin
      bad++; $display("FAIL reset_mid_restart got rd=%0d res=%h cyc=%0d want 5 00000002 33", rdo, res, dc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
